// File: rtl/reservation_station.sv
// reservation_station: ALU issue buffer that captures operands from the ALU and LSB CDBs and issues the lowest ready entry.
// Define RS_DISPATCH_BYPASS_EN to also snoop both CDBs for the instruction being dispatched.
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int OP_WIDTH = 6,
  parameter int TAG_WIDTH = 4,
  parameter logic [OP_WIDTH-1:0] NOP_OP = '0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dispatch_valid_in,
  input  logic [OP_WIDTH-1:0]  dispatch_op_in,
  input  logic [31:0]          dispatch_imm_in,
  input  logic [31:0]          dispatch_pc_in,
  input  logic [TAG_WIDTH-1:0] dispatch_dest_in,
  input  logic                 dispatch_qj_valid_in,
  input  logic [TAG_WIDTH-1:0] dispatch_qj_in,
  input  logic [31:0]          dispatch_vj_in,
  input  logic                 dispatch_qk_valid_in,
  input  logic [TAG_WIDTH-1:0] dispatch_qk_in,
  input  logic [31:0]          dispatch_vk_in,
  output logic                 full_out,
  input  logic                 alu_broadcast_in,
  input  logic [31:0]          alu_result_in,
  input  logic [TAG_WIDTH-1:0] alu_dest_in,
  input  logic                 lsb_broadcast_in,
  input  logic [31:0]          lsb_result_in,
  input  logic [TAG_WIDTH-1:0] lsb_dest_in,
  input  logic                 rob_clear_in,
  output logic [OP_WIDTH-1:0]  alu_op_out,
  output logic [31:0]          alu_imm_out,
  output logic [31:0]          alu_pc_out,
  output logic [31:0]          alu_lhs_out,
  output logic [31:0]          alu_rhs_out,
  output logic [TAG_WIDTH-1:0] alu_dest_out
);
  localparam int IW = $clog2(RS_SIZE);
  typedef struct packed {
    logic                 busy;
    logic [OP_WIDTH-1:0]  op;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [TAG_WIDTH-1:0] dest;
    logic                 qjv;
    logic [TAG_WIDTH-1:0] qj;
    logic [31:0]          vj;
    logic                 qkv;
    logic [TAG_WIDTH-1:0] qk;
    logic [31:0]          vk;
  } entry_t;
  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];
  entry_t new_e;
  logic iss_v, free_v;
  logic [IW-1:0] iss_idx, free_idx;

  // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] snoop(input logic qv, input logic [TAG_WIDTH-1:0] q, input logic [31:0] v,
                                        input logic ab, input logic [TAG_WIDTH-1:0] ad, input logic [31:0] ar,
                                        input logic lb, input logic [TAG_WIDTH-1:0] ld, input logic [31:0] lr);
    return (qv && ab && ad == q) ? {1'b0, ar} : (qv && lb && ld == q) ? {1'b0, lr} : {qv, v};
  endfunction

  always_comb begin
    iss_v = 1'b0;
    iss_idx = '0;
    free_v = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ent_q[i].busy && !ent_q[i].qjv && !ent_q[i].qkv) begin
        iss_v = 1'b1;
        iss_idx = IW'(i);
      end
      if (!ent_q[i].busy) begin
        free_v = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign full_out = !free_v;

  always_comb begin
    new_e = '{busy: 1'b1, op: dispatch_op_in, imm: dispatch_imm_in, pc: dispatch_pc_in, dest: dispatch_dest_in,
              qjv: dispatch_qj_valid_in, qj: dispatch_qj_in, vj: dispatch_vj_in,
              qkv: dispatch_qk_valid_in, qk: dispatch_qk_in, vk: dispatch_vk_in};
`ifdef RS_DISPATCH_BYPASS_EN
    {new_e.qjv, new_e.vj} = snoop(dispatch_qj_valid_in, dispatch_qj_in, dispatch_vj_in, alu_broadcast_in,
                                  alu_dest_in, alu_result_in, lsb_broadcast_in, lsb_dest_in, lsb_result_in);
    {new_e.qkv, new_e.vk} = snoop(dispatch_qk_valid_in, dispatch_qk_in, dispatch_vk_in, alu_broadcast_in,
                                  alu_dest_in, alu_result_in, lsb_broadcast_in, lsb_dest_in, lsb_result_in);
`endif
  end

  // Issue and dispatch never touch the same slot: one needs a busy entry, the other a free one.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      {ent_d[i].qjv, ent_d[i].vj} = snoop(ent_q[i].qjv, ent_q[i].qj, ent_q[i].vj, alu_broadcast_in,
                                          alu_dest_in, alu_result_in, lsb_broadcast_in, lsb_dest_in, lsb_result_in);
      {ent_d[i].qkv, ent_d[i].vk} = snoop(ent_q[i].qkv, ent_q[i].qk, ent_q[i].vk, alu_broadcast_in,
                                          alu_dest_in, alu_result_in, lsb_broadcast_in, lsb_dest_in, lsb_result_in);
      if (iss_v && iss_idx == IW'(i)) ent_d[i].busy = 1'b0;
      if (dispatch_valid_in && free_v && free_idx == IW'(i)) ent_d[i] = new_e;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && rob_clear_in)) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_op_out <= NOP_OP;
      alu_imm_out <= '0;
      alu_pc_out <= '0;
      alu_lhs_out <= '0;
      alu_rhs_out <= '0;
      alu_dest_out <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      alu_op_out <= iss_v ? ent_q[iss_idx].op : NOP_OP;
      alu_imm_out <= iss_v ? ent_q[iss_idx].imm : '0;
      alu_pc_out <= iss_v ? ent_q[iss_idx].pc : '0;
      alu_lhs_out <= iss_v ? ent_q[iss_idx].vj : '0;
      alu_rhs_out <= iss_v ? ent_q[iss_idx].vk : '0;
      alu_dest_out <= iss_v ? ent_q[iss_idx].dest : '0;
    end
  end
endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order issue buffer that sits directly upstream of the arithmetic logic unit. It accepts decoded ALU-class instructions from the dispatcher and holds each one until both source operands are known. Operands are captured from the two common-data-bus broadcasts (ALU and load/store buffer). Each cycle it issues at most one ready instruction to the combinational ALU through a registered port.

## Interface
- `RS_SIZE`, 8: number of entries; power of two, 2–16.
- `OP_WIDTH`, 6: inner opcode width.
- `TAG_WIDTH`, 4: ROB tag width.
- `NOP_OP`, 0: opcode driven to the ALU when nothing issues.

Ports:
- `clk_in` in 1: clock; all state updates on the rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: when low, all state is frozen and outputs hold.
- `dispatch_valid_in` in 1: dispatcher presents a new instruction.
- `dispatch_op_in` in OP_WIDTH: inner opcode.
- `dispatch_imm_in` in 32: immediate.
- `dispatch_pc_in` in 32: instruction PC.
- `dispatch_dest_in` in TAG_WIDTH: destination ROB tag.
- `dispatch_qj_valid_in` in 1: 1 = lhs pending on tag `dispatch_qj_in`.
- `dispatch_qj_in` in TAG_WIDTH: producer tag for lhs.
- `dispatch_vj_in` in 32: lhs value when not pending.
- `dispatch_qk_valid_in`, `dispatch_qk_in`, `dispatch_vk_in`: same three fields for rhs.
- `full_out` out 1: no free entry; dispatcher must not dispatch.
- `alu_broadcast_in` in 1, `alu_result_in` in 32, `alu_dest_in` in TAG_WIDTH: ALU CDB.
- `lsb_broadcast_in` in 1, `lsb_result_in` in 32, `lsb_dest_in` in TAG_WIDTH: LSB CDB.
- `rob_clear_in` in 1: misprediction flush.
- `alu_op_out` out OP_WIDTH: registered issue opcode.
- `alu_imm_out`, `alu_pc_out`, `alu_lhs_out`, `alu_rhs_out` out 32 each: registered operands.
- `alu_dest_out` out TAG_WIDTH: registered destination tag.

## Operation
- Each entry holds: busy, op, imm, pc, dest, qj_valid/qj/vj, qk_valid/qk/vk.
- **Dispatch.** When `dispatch_valid_in` is high and `full_out` is low, the lowest-index non-busy entry is written and marked busy. A dispatch while full is ignored.
- **Wakeup.** For every busy entry whose pending tag equals a broadcasting CDB dest, the CDB result is written into the operand value and the pending flag is cleared. Both operands of one entry may wake in the same cycle.
  - If both CDBs carry the same tag in one cycle, the ALU bus wins. Producers never do this; the rule only fixes determinism.
- **Select.** Among busy entries with both pending flags clear in the *registered* state, the lowest index is issued. Its fields are copied to the `alu_*_out` registers and the entry is freed.
  - If no entry is ready, `alu_op_out` = NOP_OP and every other `alu_*_out` is 0.
  - The ALU asserts its broadcast unconditionally; a NOP_OP result carrying dest 0 is discarded downstream.
- **Free-slot rule.** An entry freed by issue in cycle t is not re-allocatable until t+1. Dispatch uses the pre-edge busy vector.
- `full_out` = all entries busy (pre-edge state, combinational from registers).
- **Flush.** When `rob_clear_in` is high, all entries are cleared at the edge and the issue registers load NOP/0. Flush overrides a same-cycle dispatch, wakeup and issue.
- **Reset.** All entries are non-busy. `alu_op_out` = NOP_OP; `alu_imm_out`, `alu_pc_out`, `alu_lhs_out`, `alu_rhs_out`, `alu_dest_out` = 0; `full_out` = 0.
  - Priority: reset > !rdy_in > flush.

## Timing
- Dispatch of a fully ready instruction at edge t: it issues at edge t+1, and the ALU result is on the CDB during cycle t+1.
- A wakeup broadcast in cycle t makes the operand valid at edge t; the earliest issue is edge t+1, so the result is broadcast in cycle t+2.
- Sustained throughput: 1 issue per cycle.
- Dispatch-to-`full_out` update latency: 1 edge.

## Configuration
- `RS_DISPATCH_BYPASS_EN` defined: a dispatched operand whose tag matches a CDB broadcast in the same cycle is stored as ready with the CDB value. The entry is eligible to issue at the next edge.
- `RS_DISPATCH_BYPASS_EN` undefined: no dispatch-time snoop. The dispatcher guarantees it never presents a pending tag that is broadcasting in the dispatch cycle; such an operand would otherwise wait forever.

## Test plan
- Reset, then dispatch ADDI with lhs ready 5, imm 7, dest 2 -> next cycle: `alu_op_out`=ADDI, `alu_lhs_out`=5, `alu_imm_out`=7, `alu_dest_out`=2. The cycle after: NOP_OP.
- Dispatch BEQ with lhs pending on tag 3 and rhs=0x10; two cycles later LSB broadcasts tag 3 with value 0x10 -> issue one edge after the broadcast with lhs=rhs=0x10; never before.
- Dispatch 8 pending entries -> `full_out`=1. A 9th dispatch is ignored. Broadcast the tag that wakes entry 4 -> entry 4 issues, then `full_out` drops the next cycle.
- Entries 1 and 6 become ready in the same cycle -> entry 1 issues first, entry 6 issues on the following edge.
- `rob_clear_in` asserted together with a dispatch and a ready entry -> all entries empty, outputs NOP/0, `full_out`=0, and nothing issues afterward.
- With `RS_DISPATCH_BYPASS_EN`: dispatch lhs pending on tag 9 while ALU broadcasts tag 9 with value 0xAB -> issue next edge with lhs=0xAB. Without the macro, the bench asserts the dispatcher-side guarantee instead.
